// File: rtl/rect_analyzer.sv
// rect_analyzer: slices a rectangular sample stream with hysteresis and
// measures period, high time, duty cycle and amplitude in clk cycles / percent.
module rect_analyzer #(
   parameter int          CNT_W   = 27,
   parameter logic [15:0] THR_HI  = 16'd328,
   parameter logic [15:0] THR_LO  = 16'd164,
   parameter int unsigned TIMEOUT = 2**27-1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [15:0]      sample_in,
   output logic [CNT_W-1:0] period_cycles,
   output logic [CNT_W-1:0] high_cycles,
   output logic [7:0]       duty_pct,
   output logic [7:0]       amplitude_pct,
   output logic             meas_valid,
   output logic             locked,
   output logic             no_signal,
   output logic             overrun
);

   localparam int DW   = CNT_W + 7;
   localparam int IT_W = $clog2(DW + 1);
   localparam logic [IT_W-1:0]  IT_END  = IT_W'(DW);
   localparam logic [IT_W-1:0]  IT_AMP  = IT_W'(16);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [9:0]       AMP_DIV = 10'd655;

   typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;
   state_t state;

   logic             lvl, lvl_nxt, rise;
   logic [CNT_W-1:0] period_cnt, high_cnt;
   logic [15:0]      peak;

   logic             busy, done;
   logic [IT_W-1:0]  it;
   logic [CNT_W-1:0] d_div, d_rem, r_high;
   logic [DW-1:0]    d_q, dvd;
   logic [9:0]       a_rem;
   logic [15:0]      a_q;

   logic [CNT_W:0]   d_sh;
   logic [CNT_W-1:0] d_sub;
   logic             d_ge;
   logic [10:0]      a_sh;
   logic [9:0]       a_sub;
   logic             a_ge;
   logic [7:0]       duty_res, amp_res;

   always_comb begin
      lvl_nxt = lvl;
      if (sample_in >= THR_HI)
         lvl_nxt = 1'b1;
      else if (sample_in <= THR_LO)
         lvl_nxt = 1'b0;
   end

   assign rise = !lvl && (sample_in >= THR_HI);
   assign done = busy && (it == IT_END);

   // rounded duty: (high*100 + period/2) / period
   assign dvd = DW'(high_cnt) * DW'(100) + DW'(period_cnt >> 1);

   assign d_sh  = {d_rem, d_q[DW-1]};
   assign d_ge  = d_sh >= {1'b0, d_div};
   assign d_sub = d_sh[CNT_W-1:0] - d_div;
   assign a_sh  = {a_rem, a_q[15]};
   assign a_ge  = a_sh >= {1'b0, AMP_DIV};
   assign a_sub = a_sh[9:0] - AMP_DIV;

   assign duty_res = (d_q > DW'(100)) ? 8'd100 : d_q[7:0];
   assign amp_res  = (a_q > 16'd100) ? 8'd100 : a_q[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         lvl           <= 1'b0;
         period_cnt    <= '0;
         high_cnt      <= '0;
         peak          <= '0;
         busy          <= 1'b0;
         it            <= '0;
         d_div         <= '0;
         d_rem         <= '0;
         d_q           <= '0;
         r_high        <= '0;
         a_rem         <= '0;
         a_q           <= '0;
         period_cycles <= '0;
         high_cycles   <= '0;
         duty_pct      <= '0;
         amplitude_pct <= '0;
         meas_valid    <= 1'b0;
         locked        <= 1'b0;
         no_signal     <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         lvl        <= lvl_nxt;
         meas_valid <= 1'b0;
         if (busy && en) begin
            if (!done) begin
               it    <= it + 1'b1;
               d_rem <= d_ge ? d_sub : d_sh[CNT_W-1:0];
               d_q   <= {d_q[DW-2:0], d_ge};
               if (it < IT_AMP) begin
                  a_rem <= a_ge ? a_sub : a_sh[9:0];
                  a_q   <= {a_q[14:0], a_ge};
               end
            end else begin
               busy          <= 1'b0;
               period_cycles <= d_div;
               high_cycles   <= r_high;
               duty_pct      <= duty_res;
               amplitude_pct <= amp_res;
               meas_valid    <= 1'b1;
               locked        <= 1'b1;
               no_signal     <= 1'b0;
            end
         end
         if (!en) begin
            state      <= IDLE;
            busy       <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            peak       <= '0;
            overrun    <= 1'b0;
            locked     <= 1'b0;
         end else begin
            unique case (state)
               IDLE: state <= SYNC;
               SYNC: begin
                  if (rise) begin
                     period_cnt <= CNT_W'(1);
                     high_cnt   <= CNT_W'(1);
                     peak       <= sample_in;
                     state      <= MEAS;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     // a result still in flight keeps the divider
                     if (!busy || done) begin
                        busy   <= 1'b1;
                        it     <= '0;
                        d_div  <= period_cnt;
                        d_rem  <= '0;
                        d_q    <= dvd;
                        r_high <= high_cnt;
                        a_rem  <= '0;
                        a_q    <= peak;
                     end else begin
                        overrun <= 1'b1;
                     end
                     period_cnt <= CNT_W'(1);
                     high_cnt   <= CNT_W'(1);
                     peak       <= sample_in;
                  end else if (period_cnt >= TO_LIM ||
                               period_cnt == CNT_MAX) begin
                     no_signal <= 1'b1;
                     locked    <= 1'b0;
                     state     <= SYNC;
                  end else begin
                     period_cnt <= period_cnt + 1'b1;
                     if (lvl_nxt)
                        high_cnt <= high_cnt + 1'b1;
                     if (sample_in > peak)
                        peak <= sample_in;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
